credit_tx_duth: RTL

CREDIT_TX_DUTH -- requirements
Module: credit_tx_duth

---
 rtl/credit_tx_duth.sv | 72 +++++++
 1 files changed

// File: rtl/credit_tx_duth.sv
// rtl/credit_tx_duth.sv - credit-based link transmitter with a registered push port
// Flits go out only when the downstream FIFO has a free slot. Each free slot is one credit.
module credit_tx_duth #(
  parameter int DATA_WIDTH = 16,
  parameter int CREDITS    = 4,
  localparam int CNT_W     = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  credit_in,
  output logic [CNT_W-1:0]      credits_avail,
  output logic                  idle,
  output logic                  credit_err
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CREDITS);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  err_q, err_d;
  logic                  transfer;

  // in_ready depends on registered state only, so a returned credit is usable next cycle.
  assign in_ready = (cnt_q != '0);
  assign transfer = in_valid & in_ready;

  always_comb begin
    cnt_d      = cnt_q;
    err_d      = err_q;
    out_data_d = out_data_q;
    if (transfer && !credit_in) begin
      cnt_d = cnt_q - ONE_CNT;
    end else if (credit_in && !transfer) begin
      if (cnt_q == FULL_CNT) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE_CNT;
      end
    end
    if (transfer) begin
      out_data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= FULL_CNT;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= transfer;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign credits_avail = cnt_q;
  assign credit_err    = err_q;
  assign idle          = (cnt_q == FULL_CNT) & ~out_valid_q;

endmodule
